// File: rtl/axi_slv_wr_responder.sv
// rtl/axi_slv_wr_responder.sv - AXI write slave model: AW queue, W burst checker, B response queue, LFSR WREADY throttle
module axi_slv_wr_responder #(
  parameter int          AXI_ID_W        = 4,
  parameter int          AXI_DATA_W      = 32,
  parameter int          SLV_OSTDREQ_NUM = 4,
  parameter int          SLV_BRESP_NUM   = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                    aclk,
  input  logic                    srst,
  input  logic                    in_awvalid,
  output logic                    out_awready,
  input  logic [AXI_ID_W-1:0]     in_awid,
  input  logic [7:0]              in_awlen,
  input  logic                    in_wvalid,
  output logic                    out_wready,
  input  logic                    in_wlast,
  input  logic [AXI_ID_W-1:0]     in_wid,
  input  logic [AXI_DATA_W-1:0]   in_wdata,
  input  logic [AXI_DATA_W/8-1:0] in_wstrb,
  output logic                    out_bvalid,
  input  logic                    in_bready,
  output logic [AXI_ID_W-1:0]     out_bid,
  output logic [1:0]              out_bresp,
  input  logic                    throttle_en,
  output logic [15:0]             err_cnt,
  output logic [15:0]             burst_cnt
);

  localparam int AW_PW = $clog2(SLV_OSTDREQ_NUM);
  localparam int B_PW  = $clog2(SLV_BRESP_NUM);

  logic [AW_PW:0]        r_aw_wr, r_aw_rd;
  logic [AXI_ID_W-1:0]   r_aw_id  [SLV_OSTDREQ_NUM];
  logic [7:0]            r_aw_len [SLV_OSTDREQ_NUM];
  logic [B_PW:0]         r_b_wr, r_b_rd;
  logic [AXI_ID_W-1:0]   r_b_id   [SLV_BRESP_NUM];
  logic [1:0]            r_b_resp [SLV_BRESP_NUM];
  logic [7:0]            r_beat_cnt;
  logic                  r_burst_err;
  logic [15:0]           r_err_cnt, r_burst_cnt;
  logic [15:0]           r_lfsr;

  logic                  w_aw_empty, w_aw_full, w_b_empty, w_b_full;
  logic                  w_aw_push, w_w_hs, w_b_pop, w_close, w_at_len, w_id_mis, w_resp_err;
  logic [AXI_ID_W-1:0]   w_head_id;
  logic [7:0]            w_head_len;
  logic [1:0]            w_resp;
  logic                  w_lfsr_fb;
  logic                  w_unused;

  assign w_unused = ^{in_wdata, in_wstrb};

  assign w_aw_empty = (r_aw_wr == r_aw_rd);
  assign w_aw_full  = (r_aw_wr[AW_PW] != r_aw_rd[AW_PW]) &&
                      (r_aw_wr[AW_PW-1:0] == r_aw_rd[AW_PW-1:0]);
  assign w_b_empty  = (r_b_wr == r_b_rd);
  assign w_b_full   = (r_b_wr[B_PW] != r_b_rd[B_PW]) &&
                      (r_b_wr[B_PW-1:0] == r_b_rd[B_PW-1:0]);

  assign w_head_id  = r_aw_id[r_aw_rd[AW_PW-1:0]];
  assign w_head_len = r_aw_len[r_aw_rd[AW_PW-1:0]];

  assign out_awready = !w_aw_full;
  assign out_wready  = !w_aw_empty && !w_b_full && (!throttle_en || r_lfsr[0]);
  assign out_bvalid  = !w_b_empty;
  // Head fields are masked while empty so the idle/reset value is zero.
  assign out_bid     = w_b_empty ? '0 : r_b_id[r_b_rd[B_PW-1:0]];
  assign out_bresp   = w_b_empty ? 2'b00 : r_b_resp[r_b_rd[B_PW-1:0]];
  assign err_cnt     = r_err_cnt;
  assign burst_cnt   = r_burst_cnt;

  assign w_aw_push  = in_awvalid && out_awready;
  assign w_w_hs     = in_wvalid && out_wready;
  assign w_b_pop    = out_bvalid && in_bready;
  assign w_at_len   = (r_beat_cnt == w_head_len);
  assign w_id_mis   = (in_wid != w_head_id);
  assign w_close    = w_w_hs && (in_wlast || w_at_len);
  // A WLAST that disagrees with the length boundary is an error either way.
  assign w_resp_err = (in_wlast != w_at_len) || r_burst_err || w_id_mis;
  assign w_resp     = w_resp_err ? 2'b10 : 2'b00;
  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge aclk) begin
    if (w_aw_push) begin
      r_aw_id[r_aw_wr[AW_PW-1:0]]  <= in_awid;
      r_aw_len[r_aw_wr[AW_PW-1:0]] <= in_awlen;
    end
    if (w_close) begin
      r_b_id[r_b_wr[B_PW-1:0]]   <= w_head_id;
      r_b_resp[r_b_wr[B_PW-1:0]] <= w_resp;
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_aw_wr     <= '0;
      r_aw_rd     <= '0;
      r_b_wr      <= '0;
      r_b_rd      <= '0;
      r_beat_cnt  <= '0;
      r_burst_err <= 1'b0;
      r_err_cnt   <= '0;
      r_burst_cnt <= '0;
      r_lfsr      <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      if (w_aw_push) r_aw_wr <= r_aw_wr + 1'b1;
      if (w_b_pop)   r_b_rd  <= r_b_rd + 1'b1;
      if (w_close) begin
        r_aw_rd     <= r_aw_rd + 1'b1;
        r_b_wr      <= r_b_wr + 1'b1;
        r_beat_cnt  <= '0;
        r_burst_err <= 1'b0;
        r_burst_cnt <= r_burst_cnt + 16'd1;
        if (w_resp_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
      end else if (w_w_hs) begin
        r_beat_cnt  <= r_beat_cnt + 8'd1;
        r_burst_err <= r_burst_err || w_id_mis;
      end
    end
  end

endmodule
